// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory-access stage.
//   - bit positions inside the 8-bit MEM control bundle
//   - write-back select encodings
//   - FSM state encoding
//   - data-memory byte-enable patterns and a helper to pick one
package mem_pkg;

  localparam int unsigned MS_MEM_READ  = 0;
  localparam int unsigned MS_MEM_WRITE = 1;
  localparam int unsigned MS_REG_WRITE = 2;
  localparam int unsigned MS_WBSEL_LO  = 3;
  localparam int unsigned MS_WBSEL_HI  = 4;
  localparam int unsigned MS_BYTE      = 5;
  localparam int unsigned MS_SIGNED    = 6;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC1 = 2'b10,
    WB_IMM = 2'b11
  } wb_sel_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic [1:0] byte_enable(input logic is_byte, input logic addr0);
    if (!is_byte)  return BE_WORD;
    else if (addr0) return BE_HI;
    else           return BE_LO;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: turns raw 16-bit read data into the register value.
//   rdata     in  raw memory word
//   addr0     in  byte address bit 0 (selects the lane for byte loads)
//   is_byte   in  1 = byte load, 0 = word load
//   is_signed in  1 = sign-extend byte, 0 = zero-extend
//   value     out aligned load value
module mem_load_align
  import mem_pkg::*;
(
  input  logic [15:0] rdata,
  input  logic        addr0,
  input  logic        is_byte,
  input  logic        is_signed,
  output logic [15:0] value
);

  logic [7:0] lane;

  always_comb begin
    lane = addr0 ? rdata[15:8] : rdata[7:0];
    if (!is_byte)
      value = rdata;
    else if (is_signed)
      value = {{8{lane[7]}}, lane};
    else
      value = {8'h00, lane};
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage.
// Accepts the EXE->MEM bundle, performs loads/stores over a req/ready data
// memory port (stalling upstream while an access is outstanding) and drives a
// registered MEM->WB bundle.
//   in_valid/alu_value_in/store_value_in/imm_in/pc_in/rd_in/mem_signals_in : EXE->MEM bundle
//   stall_out                                                               : hold upstream bundle
//   dmem_req/we/addr/wdata/be, dmem_rdata/ready                             : data memory port
//   wb_valid/wb_reg_write/wb_rd/wb_value                                    : MEM->WB bundle
//   misalign_err                                                            : misaligned word access pulse
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] alu_value_in,
  input  logic [DW-1:0] store_value_in,
  input  logic [DW-1:0] imm_in,
  input  logic [DW-1:0] pc_in,
  input  logic [RW-1:0] rd_in,
  input  logic [7:0]    mem_signals_in,
  output logic          stall_out,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [1:0]    dmem_be,
  input  logic [DW-1:0] dmem_rdata,
  input  logic          dmem_ready,
  output logic          wb_valid,
  output logic          wb_reg_write,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_value,
  output logic          misalign_err
);

  mem_state_e state_q, state_d;

  // Operands latched at accept time for use on the completion edge
  logic          byte_q, signed_q, regwrite_q;
  wb_sel_e       wbsel_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] pc_q, imm_q;

  logic          is_mem, is_byte, misaligned, start_access;
  wb_sel_e       wbsel_in;
  logic [DW-1:0] load_value;

  // Next values of the registered outputs
  logic          req_d, we_d, wb_valid_d, wb_reg_write_d, misalign_d;
  logic [DW-1:0] addr_d, wdata_d, wb_value_d;
  logic [1:0]    be_d;
  logic [RW-1:0] wb_rd_d;

  logic unused_reserved;
  assign unused_reserved = mem_signals_in[7];

  assign is_mem     = mem_signals_in[MS_MEM_READ] | mem_signals_in[MS_MEM_WRITE];
  assign is_byte    = mem_signals_in[MS_BYTE];
  assign misaligned = is_mem & ~is_byte & alu_value_in[0];
  assign wbsel_in   = wb_sel_e'(mem_signals_in[MS_WBSEL_HI:MS_WBSEL_LO]);
  assign start_access = (state_q == IDLE) & in_valid & is_mem & ~misaligned;
  assign stall_out  = (state_q == ACCESS);

  mem_load_align u_align (
    .rdata     (dmem_rdata),
    .addr0     (dmem_addr[0]),
    .is_byte   (byte_q),
    .is_signed (signed_q),
    .value     (load_value)
  );

  function automatic logic [DW-1:0] wb_select(input wb_sel_e sel, input logic [DW-1:0] alu,
                                              input logic [DW-1:0] mem, input logic [DW-1:0] pc,
                                              input logic [DW-1:0] imm);
    case (sel)
      WB_ALU:  return alu;
      WB_MEM:  return mem;
      WB_PC1:  return pc + DW'(1);
      default: return imm;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_access) state_d = ACCESS;
      ACCESS:  if (dmem_ready)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered port outputs
  always_comb begin
    req_d          = dmem_req;
    we_d           = dmem_we;
    addr_d         = dmem_addr;
    wdata_d        = dmem_wdata;
    be_d           = dmem_be;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write;
    wb_rd_d        = wb_rd;
    wb_value_d     = wb_value;
    misalign_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = mem_signals_in[MS_REG_WRITE];
            wb_rd_d        = rd_in;
            wb_value_d     = wb_select(wbsel_in, alu_value_in, '0, pc_in, imm_in);
          end else if (misaligned) begin
            wb_valid_d     = 1'b1;
            wb_reg_write_d = 1'b0;
            wb_rd_d        = rd_in;
            misalign_d     = 1'b1;
          end else begin
            req_d   = 1'b1;
            we_d    = mem_signals_in[MS_MEM_WRITE];
            addr_d  = alu_value_in;
            wdata_d = is_byte ? {store_value_in[7:0], store_value_in[7:0]} : store_value_in;
            be_d    = byte_enable(is_byte, alu_value_in[0]);
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          req_d          = 1'b0;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = regwrite_q & ~dmem_we;
          wb_rd_d        = rd_q;
          // dmem_addr still holds the latched ALU value; stores have no MEM data
          wb_value_d     = wb_select(wbsel_q, dmem_addr, dmem_we ? '0 : load_value, pc_q, imm_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_be      <= '0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= '0;
      wb_value     <= '0;
      misalign_err <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      regwrite_q   <= 1'b0;
      wbsel_q      <= WB_ALU;
      rd_q         <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
    end else begin
      dmem_req     <= req_d;
      dmem_we      <= we_d;
      dmem_addr    <= addr_d;
      dmem_wdata   <= wdata_d;
      dmem_be      <= be_d;
      wb_valid     <= wb_valid_d;
      wb_reg_write <= wb_reg_write_d;
      wb_rd        <= wb_rd_d;
      wb_value     <= wb_value_d;
      misalign_err <= misalign_d;
      if (start_access) begin
        byte_q     <= is_byte;
        signed_q   <= mem_signals_in[MS_SIGNED];
        regwrite_q <= mem_signals_in[MS_REG_WRITE];
        wbsel_q    <= wbsel_in;
        rd_q       <= rd_in;
        pc_q       <= pc_in;
        imm_q      <= imm_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] alu_value_in, store_value_in, imm_in, pc_in;
  logic [2:0]  rd_in;
  logic [7:0]  mem_signals_in;
  logic        stall_out, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [1:0]  dmem_be;
  logic        dmem_ready;
  logic        wb_valid, wb_reg_write, misalign_err;
  logic [2:0]  wb_rd;
  logic [15:0] wb_value;

  int total = 0;
  int bad   = 0;

  // Control bundle encodings: RD=1 WR=2 RW=4 WbSel<<3 BYTE=0x20 SIGNED=0x40
  localparam logic [7:0] C_ALU      = 8'h04;
  localparam logic [7:0] C_PC1      = 8'h14;
  localparam logic [7:0] C_IMM      = 8'h1C;
  localparam logic [7:0] C_MEMSEL   = 8'h0C;
  localparam logic [7:0] C_LW       = 8'h0D;
  localparam logic [7:0] C_LB_S     = 8'h6D;
  localparam logic [7:0] C_LB_U     = 8'h2D;
  localparam logic [7:0] C_SB       = 8'h26;
  localparam logic [7:0] C_SW       = 8'h06;
  localparam logic [7:0] C_RDWR     = 8'h07;

  mem_access_stage #(.DW(16), .RW(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .alu_value_in   (alu_value_in),
    .store_value_in (store_value_in),
    .imm_in         (imm_in),
    .pc_in          (pc_in),
    .rd_in          (rd_in),
    .mem_signals_in (mem_signals_in),
    .stall_out      (stall_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_wdata     (dmem_wdata),
    .dmem_be        (dmem_be),
    .dmem_rdata     (dmem_rdata),
    .dmem_ready     (dmem_ready),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_rd          (wb_rd),
    .wb_value       (wb_value),
    .misalign_err   (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] ms, input logic [15:0] alu,
                       input logic [15:0] st, input logic [15:0] imm, input logic [15:0] pc,
                       input logic [2:0] rd);
    in_valid = v; mem_signals_in = ms; alu_value_in = alu; store_value_in = st;
    imm_in = imm; pc_in = pc; rd_in = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0;
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    tick(); tick();
    total++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, wb_valid, wb_reg_write, wb_rd,
         wb_value, misalign_err, stall_out} !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b stall=%b wbv=%b val=%h want all 0",
                      dmem_req, stall_out, wb_valid, wb_value);
    end
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    drive(1'b1, C_ALU, 16'h1234, 16'h0, 16'h0, 16'h0010, 3'd5);
    total++;
    if (stall_out !== 1'b0) begin bad++; $display("FAIL alu_stall_pre: got %b want 0", stall_out); end
    tick();
    drive(1'b0, C_ALU, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (wb_valid !== 1'b1 || wb_rd !== 3'd5 || wb_value !== 16'h1234 || wb_reg_write !== 1'b1 ||
        stall_out !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL alu_retire: got v=%b rd=%0d val=%h rw=%b stall=%b want 1 5 1234 1 0",
                      wb_valid, wb_rd, wb_value, wb_reg_write, stall_out);
    end
    tick();
    total++;
    if (wb_valid !== 1'b0 || wb_value !== 16'h1234 || wb_rd !== 3'd5) begin
      bad++; $display("FAIL alu_idle_hold: got v=%b val=%h rd=%0d want 0 1234 5", wb_valid, wb_value, wb_rd);
    end
  endtask

  task automatic test_wbsel();
    drive(1'b1, C_PC1, 16'h1111, 16'h0, 16'h2222, 16'hFFFF, 3'd1);
    tick();
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'h0000) begin
      bad++; $display("FAIL pc1_wrap: got v=%b val=%h want 1 0000", wb_valid, wb_value);
    end
    drive(1'b1, C_IMM, 16'h1111, 16'h0, 16'hCAFE, 16'h0007, 3'd2);
    tick();
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'hCAFE || wb_rd !== 3'd2) begin
      bad++; $display("FAIL imm_sel: got v=%b val=%h rd=%0d want 1 cafe 2", wb_valid, wb_value, wb_rd);
    end
    drive(1'b1, C_MEMSEL, 16'h1111, 16'h0, 16'hCAFE, 16'h0007, 3'd3);
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'h0000 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL memsel_nonload: got v=%b val=%h req=%b want 1 0000 0", wb_valid, wb_value, dmem_req);
    end
    // ready in IDLE is ignored
    dmem_ready = 1'b1; dmem_rdata = 16'h5555;
    tick();
    total++;
    if (wb_valid !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL idle_ready_ignored: got v=%b stall=%b want 0 0", wb_valid, stall_out);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_word_load();
    int stalls = 0;
    int early  = 0;
    drive(1'b1, C_LW, 16'h0040, 16'h0, 16'h0, 16'h0020, 3'd4);
    tick();
    if (stall_out) stalls++;
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 16'h0040 || dmem_be !== 2'b11) begin
      bad++; $display("FAIL lw_issue: got req=%b we=%b addr=%h be=%b want 1 0 0040 11",
                      dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (stall_out) stalls++;
      if (wb_valid) early++;
      total++;
      if (dmem_req !== 1'b1 || dmem_addr !== 16'h0040 || dmem_be !== 2'b11) begin
        bad++; $display("FAIL lw_hold: got req=%b addr=%h be=%b want 1 0040 11", dmem_req, dmem_addr, dmem_be);
      end
    end
    dmem_ready = 1'b1; dmem_rdata = 16'hBEEF;
    tick();
    if (stall_out) stalls++;
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'hBEEF || wb_reg_write !== 1'b1 || wb_rd !== 3'd4 ||
        dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      bad++; $display("FAIL lw_done: got v=%b val=%h rw=%b rd=%0d req=%b want 1 beef 1 4 0",
                      wb_valid, wb_value, wb_reg_write, wb_rd, dmem_req);
    end
    total++;
    if (stalls != 4 || early != 0) begin
      bad++; $display("FAIL lw_stall_count: got stalls=%0d early=%0d want 4 0", stalls, early);
    end
    dmem_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    // upstream presents the next ALU op right after the load completes
    drive(1'b1, C_ALU, 16'h7777, 16'h0, 16'h0, 16'h0, 3'd6);
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'h7777 || wb_rd !== 3'd6) begin
      bad++; $display("FAIL b2b_alu: got v=%b val=%h rd=%0d want 1 7777 6", wb_valid, wb_value, wb_rd);
    end
  endtask

  task automatic test_byte_load(input logic [7:0] ms, input logic [15:0] expv, input string nm);
    dmem_ready = 1'b1; dmem_rdata = 16'h80FF;
    drive(1'b1, ms, 16'h0041, 16'h0, 16'h0, 16'h0, 3'd7);
    tick();
    total++;
    if (dmem_req !== 1'b1 || dmem_be !== 2'b10 || wb_valid !== 1'b0 || stall_out !== 1'b1) begin
      bad++; $display("FAIL %s_issue: got req=%b be=%b v=%b stall=%b want 1 10 0 1",
                      nm, dmem_req, dmem_be, wb_valid, stall_out);
    end
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (wb_valid !== 1'b1 || wb_value !== expv || wb_reg_write !== 1'b1 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL %s_done: got v=%b val=%h rw=%b want 1 %h 1", nm, wb_valid, wb_value, wb_reg_write, expv);
    end
    dmem_ready = 1'b0;
    tick();
  endtask

  task automatic test_stores();
    drive(1'b1, C_SB, 16'h0003, 16'h00A5, 16'h0, 16'h0, 3'd2);
    tick();
    total++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_be !== 2'b10 || dmem_wdata !== 16'hA5A5 ||
        dmem_addr !== 16'h0003) begin
      bad++; $display("FAIL sb_issue: got req=%b we=%b be=%b wd=%h want 1 1 10 a5a5",
                      dmem_req, dmem_we, dmem_be, dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    dmem_ready = 1'b0;
    total++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL sb_done: got v=%b rw=%b req=%b want 1 0 0", wb_valid, wb_reg_write, dmem_req);
    end
    tick();
    // read+write together behaves as a word write
    drive(1'b1, C_RDWR, 16'h0004, 16'h1357, 16'h0, 16'h0, 3'd1);
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (dmem_we !== 1'b1 || dmem_be !== 2'b11 || dmem_wdata !== 16'h1357) begin
      bad++; $display("FAIL rdwr_is_write: got we=%b be=%b wd=%h want 1 11 1357", dmem_we, dmem_be, dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    tick();
  endtask

  task automatic test_misalign();
    drive(1'b1, C_SW, 16'h0005, 16'h4321, 16'h0, 16'h0, 3'd3);
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (misalign_err !== 1'b1 || wb_valid !== 1'b1 || wb_reg_write !== 1'b0 || dmem_req !== 1'b0 ||
        stall_out !== 1'b0) begin
      bad++; $display("FAIL sw_misalign: got err=%b v=%b rw=%b req=%b stall=%b want 1 1 0 0 0",
                      misalign_err, wb_valid, wb_reg_write, dmem_req, stall_out);
    end
    tick();
    total++;
    if (misalign_err !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL misalign_pulse: got err=%b v=%b want 0 0", misalign_err, wb_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, C_LW, 16'h0080, 16'h0, 16'h0, 16'h0, 3'd1);
    tick();
    total++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
      bad++; $display("FAIL rst_mid_pre: got req=%b stall=%b want 1 1", dmem_req, stall_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0 || wb_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_async: got req=%b stall=%b v=%b want 0 0 0", dmem_req, stall_out, wb_valid);
    end
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    #1 rst_n = 1'b1;
    drive(1'b1, C_ALU, 16'h0ABC, 16'h0, 16'h0, 16'h0, 3'd3);
    tick();
    drive(1'b0, 8'h00, 16'h0, 16'h0, 16'h0, 16'h0, 3'd0);
    total++;
    if (wb_valid !== 1'b1 || wb_value !== 16'h0ABC || stall_out !== 1'b0 || dmem_req !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: got v=%b val=%h stall=%b req=%b want 1 0abc 0 0",
                      wb_valid, wb_value, stall_out, dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_wbsel();
    test_word_load();
    test_back_to_back();
    test_byte_load(C_LB_S, 16'hFF80, "lb_signed");
    test_byte_load(C_LB_U, 16'h0080, "lb_unsigned");
    test_stores();
    test_misalign();
    test_reset_mid_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Memory-access stage of the 16-bit pipeline. It sits directly downstream of the EXE→MEM pipeline register and consumes its outputs: ALU value, register store value, immediate, PC, Rd, and the 8-bit MEM control bundle. It performs data-memory loads and stores over a variable-latency req/ready interface and stalls upstream while an access is outstanding. It drives a registered MEM→WB result bundle into write-back.

Parameters:
- DW, 16, datapath / address width
- RW, 3, register index width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  EXE→MEM bundle holds a live instruction
- alu_value_in  in  DW  ALU result; memory address for loads/stores
- store_value_in  in  DW  store data
- imm_in  in  DW  immediate
- pc_in  in  DW  instruction PC
- rd_in  in  RW  destination register
- mem_signals_in  in  8  control bundle:
  - [0] MemRead
  - [1] MemWrite
  - [2] RegWrite
  - [4:3] WbSel (00 ALU, 01 MEM, 10 PC+1, 11 IMM)
  - [5] ByteAccess
  - [6] SignedLoad
  - [7] reserved, ignored
- stall_out  out  1  upstream must hold the EXE→MEM bundle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DW  byte address
- dmem_wdata  out  DW  write data
- dmem_be  out  2  byte enables ([0] low byte, [1] high byte)
- dmem_rdata  in  DW  read data, valid when dmem_ready = 1
- dmem_ready  in  1  access complete
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  RW  destination register
- wb_value  out  DW  write-back value
- misalign_err  out  1  one-cycle pulse on a misaligned word access

Behaviour:
- Reset: all outputs 0 and FSM in IDLE. Applies immediately and asynchronously, including mid-access; the outstanding request is abandoned and dmem_req drops at once.
- FSM states: IDLE and ACCESS. stall_out = (state == ACCESS), purely from state.
- IDLE, in_valid = 0: wb_valid = 0 next cycle; all other wb_* fields hold.
- IDLE, in_valid = 1, no MemRead/MemWrite: next edge retires the instruction (1-cycle latency):
  - wb_valid = 1, wb_reg_write = RegWrite, wb_rd = rd_in
  - wb_value chosen by WbSel; PC+1 wraps modulo 2^16
  - WbSel = MEM on a non-load yields 0
- IDLE, in_valid = 1, MemRead or MemWrite:
  - Word access with alu_value_in[0] = 1: no memory access. Next edge gives wb_valid = 1, wb_reg_write = 0, misalign_err = 1.
  - Otherwise the next edge latches address, data, control, rd and pc internally. It registers dmem_req = 1, dmem_we = MemWrite and dmem_addr, then enters ACCESS.
  - MemRead and MemWrite both set: treated as a write.
- Write data and byte enables:
  - Word: dmem_wdata = store value, dmem_be = 11.
  - Byte: dmem_wdata = {low byte, low byte}; dmem_be = 01 if addr[0] = 0, 10 if addr[0] = 1.
  - Loads drive dmem_be with the same pattern.
- ACCESS:
  - dmem_req and all dmem_* outputs are held stable. in_valid and the upstream inputs are ignored.
  - Each edge with dmem_ready = 0 stays in ACCESS.
  - The edge with dmem_ready = 1 returns to IDLE, drops dmem_req and pulses wb_valid.
  - Load: wb_value = aligned rdata. Byte loads take the lane selected by addr[0], sign-extended if SignedLoad else zero-extended. wb_reg_write = RegWrite.
  - Store: wb_reg_write = 0.
  - Non-MEM WbSel values use the latched operands.
- Minimum memory-op latency is 2 edges: accept, then ready. dmem_ready may be high on the first ACCESS cycle.
- The held upstream instruction is accepted on the first IDLE cycle after completion. No instruction is accepted on the completion edge.
- dmem_ready while in IDLE is ignored.

Decomposition:
- Shared package mem_pkg:
  - MEM_signals bit-position constants
  - WbSel encodings
  - FSM state enum
  - byte-enable constants
- One combinational sub-module, mem_load_align: rdata, addr[0], byte, signed → aligned 16-bit load value.

Test Plan:
- Reset mid-access: assert rst_n = 0 while in ACCESS with dmem_req = 1 → dmem_req, stall_out, wb_valid = 0 immediately. After release the FSM is in IDLE and the first new instruction retires normally.
- ALU instruction, WbSel = 00, alu = 0x1234, rd = 5, RegWrite = 1 → next cycle wb_valid = 1, wb_rd = 5, wb_value = 0x1234, stall_out never high.
- PC+1 select with pc = 0xFFFF → wb_value = 0x0000 (wrap).
- Word load at 0x0040, memory ready after 3 wait cycles with rdata = 0xBEEF:
  - stall_out high for 4 cycles
  - dmem_addr = 0x0040 and dmem_be = 11 stable throughout
  - single wb_valid pulse with wb_value = 0xBEEF
- Signed byte load at 0x0041, rdata = 0x80FF → dmem_be = 10, wb_value = 0xFF80. Same case unsigned → 0x0080.
- Byte store 0x00A5 at 0x0003 → dmem_we = 1, dmem_be = 10, dmem_wdata = 0xA5A5; completion gives wb_valid = 1, wb_reg_write = 0.
- Word store at 0x0005 → no dmem_req; misalign_err and wb_valid pulse once; wb_reg_write = 0.
